// File: rtl/nios2_oci_dct_pkg.sv
// Shared definitions for the OCI data-trace packer: atom/word geometry, idle timeout and
// the flush sequencing states.
package nios2_oci_dct_pkg;

  localparam int ATOM_W         = 2;
  localparam int ATOMS_PER_WORD = 15;
  localparam int BUF_W          = ATOM_W * ATOMS_PER_WORD;
  localparam int CNT_W          = 4;
  localparam int FLUSH_TIMEOUT  = 64;
  localparam int TMR_W          = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    FLUSH_EMIT  = 2'd1,
    FLUSH_DRAIN = 2'd2,
    DONE        = 2'd3
  } dct_state_e;

endpackage

// File: rtl/nios2_oci_dct_idle_timer.sv
// Counts idle cycles while a partial word sits in the packing buffer; saturates at the
// timeout so the forced emit can wait for the output register to free up.
module nios2_oci_dct_idle_timer
  import nios2_oci_dct_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_o
);

  localparam logic [TMR_W-1:0] TERM = TMR_W'(FLUSH_TIMEOUT);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i && (cnt_q != TERM)) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A timeout of zero disables the forced emit entirely.
  assign expire_o = (FLUSH_TIMEOUT != 0) && (cnt_q == TERM);

endmodule

// File: rtl/nios2_oci_dct_packer_ctrl.sv
// Packs 2-bit trace atoms into 30-bit words, hands them to the trace-word writer and
// sequences the end-of-test flush.
//   state       | meaning
//   RUN         | accepting atoms, full/idle-timeout emits
//   FLUSH_EMIT  | atoms blocked, push out any partial word
//   FLUSH_DRAIN | wait for the writer to take the last word
//   DONE        | one-cycle flush_done pulse
module nios2_oci_dct_packer_ctrl
  import nios2_oci_dct_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             trace_enable,
  input  logic             atom_valid,
  input  logic [ATOM_W-1:0] atom_data,
  output logic             atom_ready,
  input  logic             flush_req,
  output logic             tw_valid,
  output logic [BUF_W-1:0] tw_data,
  output logic [CNT_W-1:0] tw_count,
  input  logic             tw_ready,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count,
  output logic             flush_done
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(ATOMS_PER_WORD);

  dct_state_e       state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tw_valid_q, tw_valid_d;
  logic [BUF_W-1:0] tw_data_q, tw_data_d;
  logic [CNT_W-1:0] tw_count_q, tw_count_d;

  logic load_ok, full, empty, in_run, accept;
  logic emit_full, emit_idle, emit_flush, emit;
  logic tmr_run, tmr_clear, tmr_expire;

  assign load_ok    = !tw_valid_q || tw_ready;
  assign full       = (cnt_q == MAX_CNT);
  assign empty      = (cnt_q == '0);
  assign in_run     = (state_q == RUN);
  assign atom_ready = trace_enable && in_run && (!full || load_ok);
  assign accept     = atom_valid && atom_ready;

  // An idle emit never coincides with an accept: the accept restarts the idle count.
  assign emit_full  = in_run && full && load_ok;
  assign emit_idle  = in_run && tmr_expire && !accept && !empty && !full && load_ok;
  assign emit_flush = (state_q == FLUSH_EMIT) && !empty && load_ok;
  assign emit       = emit_full || emit_idle || emit_flush;

  assign tmr_run    = in_run && !empty && !full && !accept;
  assign tmr_clear  = accept || emit;

  nios2_oci_dct_idle_timer u_idle_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (tmr_clear),
    .run_i    (tmr_run),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      RUN:         if (flush_req) state_d = FLUSH_EMIT;
      FLUSH_EMIT:  if (empty || load_ok) state_d = FLUSH_DRAIN;
      FLUSH_DRAIN: if (!tw_valid_q || tw_ready) state_d = DONE;
      DONE: begin
        flush_done = 1'b1;
        state_d    = RUN;
      end
      default:     state_d = RUN;
    endcase
  end

  always_comb begin
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    tw_valid_d = tw_valid_q;
    tw_data_d  = tw_data_q;
    tw_count_d = tw_count_q;
    if (tw_ready) tw_valid_d = 1'b0;
    if (emit) begin
      tw_valid_d = 1'b1;
      tw_data_d  = buf_q;
      tw_count_d = cnt_q;
      buf_d      = '0;
      cnt_d      = '0;
    end
    // Shifting into the already-cleared buffer gives the no-bubble restart after an emit.
    if (accept) begin
      buf_d = {buf_d[BUF_W-ATOM_W-1:0], atom_data};
      cnt_d = cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      buf_q      <= '0;
      cnt_q      <= '0;
      tw_valid_q <= 1'b0;
      tw_data_q  <= '0;
      tw_count_q <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      tw_valid_q <= tw_valid_d;
      tw_data_q  <= tw_data_d;
      tw_count_q <= tw_count_d;
    end
  end

  assign tw_valid   = tw_valid_q;
  assign tw_data    = tw_data_q;
  assign tw_count   = tw_count_q;
  assign dct_buffer = buf_q;
  assign dct_count  = cnt_q;

endmodule
